// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DEF_DATA_W / DEF_NUM_REGS : default geometry (32 x 32-bit)
//   REG_ZERO                  : index of the hard-wired zero register
//   port_lsb()                : LSB of port slice `port` in a packed bus of `width`-bit fields
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int REG_ZERO     = 0;

  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: request/response bundle of the register file.
//   write_enable/write_reg/write_d : write port
//   read_reg (packed)              : read indices, port i at [i*ADDR_W +: ADDR_W]
//   read_d   (packed)              : read data, same packing
//   read_busy                      : per-port pending (load-use) flag
//   pend_set/pend_reg              : mark a register pending at load issue
//   any_pending                    : OR of all pending bits
// master = datapath driving the file, slave = the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NUM_REGS),
  parameter int NUM_RD = 2
);
  logic                       write_enable;
  logic [ADDR_W-1:0]          write_reg;
  logic [DATA_W-1:0]          write_d;
  logic [NUM_RD*ADDR_W-1:0]   read_reg;
  logic [NUM_RD*DATA_W-1:0]   read_d;
  logic [NUM_RD-1:0]          read_busy;
  logic                       pend_set;
  logic [ADDR_W-1:0]          pend_reg;
  logic                       any_pending;

  modport master (
    output write_enable, write_reg, write_d, read_reg, pend_set, pend_reg,
    input  read_d, read_busy, any_pending
  );
  modport slave (
    input  write_enable, write_reg, write_d, read_reg, pend_set, pend_reg,
    output read_d, read_busy, any_pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register for load-use detection.
//   clk, rst           : clock, async active-high reset (clears all pending bits)
//   pend_set/pend_reg  : set pending at the edge (load issued)
//   clr_en/clr_reg     : clear pending at the edge (qualified write from the top)
//   read_reg (packed)  : per-port lookup indices
//   read_busy          : pending[read_reg[i]], masked while bypass data arrives
//   any_pending        : OR of all pending bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_reg,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_reg,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD-1:0]        read_busy,
  output logic                     any_pending
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                set_ok;

  // Out-of-range and zero-register marks are dropped so reg0 can never go pending.
  always_comb begin
    set_ok = pend_set && !rst && ({1'b0, pend_reg} < DEPTH) &&
             !((ZERO_REG != 0) && (pend_reg == ADDR_W'(REG_ZERO)));
  end

  // Set is applied after clear: on the same index the new load is still outstanding.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_reg]  = 1'b0;
    if (set_ok) pend_d[pend_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] idx;
    logic              arriving;
    assign idx      = read_reg[port_lsb(i, ADDR_W) +: ADDR_W];
    // Data forwarded this cycle satisfies the consumer, so it is not stalled.
    assign arriving = (BYPASS != 0) && clr_en && (clr_reg == idx);
    assign read_busy[i] = ({1'b0, idx} < DEPTH) && pend_q[idx] && !arriving;
  end

  assign any_pending = |pend_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD combinational read ports,
// one write port, optional write-first bypass, hard-wired zero register and
// a pending scoreboard.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset, clears data and pending bits
//   bus : regfile_mp_if slave (write port, read ports, scoreboard)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]               rd_busy;
  logic                            rd_any;
  logic                            wr_ok;

  // A write is accepted only out of reset, in range and not to a suppressed reg0.
  // Gating with rst also keeps bypass quiet so outputs read 0 during reset.
  always_comb begin
    wr_ok = bus.write_enable && !rst && ({1'b0, bus.write_reg} < DEPTH) &&
            !((ZERO_REG != 0) && (bus.write_reg == ADDR_W'(REG_ZERO)));
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[bus.write_reg] = bus.write_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              ok;
    logic              byp;
    assign idx = bus.read_reg[port_lsb(i, ADDR_W) +: ADDR_W];
    assign ok  = ({1'b0, idx} < DEPTH) &&
                 !((ZERO_REG != 0) && (idx == ADDR_W'(REG_ZERO)));
    // wr_ok already excludes reg0 and out-of-range, so bypass never leaks there.
    assign byp = (BYPASS != 0) && wr_ok && (bus.write_reg == idx);
    assign rd_data[i] = !ok ? '0 : (byp ? bus.write_d : mem_q[idx]);
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .pend_set    (bus.pend_set),
    .pend_reg    (bus.pend_reg),
    .clr_en      (wr_ok),
    .clr_reg     (bus.write_reg),
    .read_reg    (bus.read_reg),
    .read_busy   (rd_busy),
    .any_pending (rd_any)
  );

  assign bus.read_d      = rd_data;
  assign bus.read_busy   = rd_busy;
  assign bus.any_pending = rd_any;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file. Successor to the 32x32 two-read/one-write CPU register file.
- Adds asynchronous clear, hard-wired zero register, optional write-to-read bypass, and a per-register pending scoreboard for load-use hazard detection.
- Sits in the decode stage of the MIPS datapath. The scoreboard is set at load issue and cleared at writeback.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (>=2).
- ADDR_W, $clog2(NUM_REGS), register index width.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, is never pending.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_enable  in  1  commit write_d to write_reg at the rising edge.
- write_reg  in  ADDR_W  write index.
- write_d  in  DATA_W  write data.
- read_reg  in  NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W].
- read_d  out  NUM_RD*DATA_W  packed read data, same packing.
- read_busy  out  NUM_RD  port i index has an outstanding pending write.
- pend_set  in  1  mark pend_reg pending (load issued).
- pend_reg  in  ADDR_W  index to mark.
- any_pending  out  1  OR of all pending bits.

Behaviour:
- Reset is asynchronous: rst high immediately clears all NUM_REGS registers to 0 and all pending bits to 0. Outputs settle to read_d=0, read_busy=0, any_pending=0 with no clock required.
- Writes are ignored while rst is high. Release is synchronous to clk; the first write lands on the first rising edge with rst low.
- Write: at posedge, if write_enable and not (ZERO_REG and write_reg==0), then reg[write_reg] <= write_d. Write latency is 1 cycle.
- Read path is combinational (0-cycle): read_d[i] = reg[read_reg[i]].
- Bypass (BYPASS=1): if write_enable and write_reg==read_reg[i] and the index is not zero-suppressed, read_d[i] = write_d in the same cycle (write-first).
- BYPASS=0: read_d[i] returns the old value until the edge.
- ZERO_REG=1: read_d[i]=0 whenever read_reg[i]==0, regardless of write or bypass.
- Index >= NUM_REGS (non-power-of-2 depth):
  - write is dropped;
  - read returns 0;
  - pend_set is dropped.
- Scoreboard, one bit per register:
  - posedge with pend_set: pending[pend_reg] <= 1.
  - posedge with write_enable: pending[write_reg] <= 0.
  - Same index, both in one cycle: set wins. The write completes an older producer; the new load is still outstanding.
  - Different indices: both apply independently.
  - Register 0 is never pending when ZERO_REG=1.
- read_busy[i] = pending[read_reg[i]], masked to 0 when write_enable and write_reg==read_reg[i] and BYPASS=1 (data is arriving now). An index that is set in the same cycle shows busy only from the next cycle.
- Multiple read ports may address the same index; all ports return identical data.
- Reset asserted mid-operation: an in-flight write at that edge is lost, and all pending bits clear.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/NUM_REGS constants;
  - the zero-register index constant REG_ZERO=0;
  - the packing helper function for port slices.
- One sub-module, regfile_scoreboard: pending vector, set/clear priority, read_busy lookup and bypass mask. The data array stays in regfile_mp.

Test Plan:
- Async reset: preload reg5=500, assert rst between edges -> read_reg port0=5 gives read_d=0 immediately, any_pending=0 immediately.
- Write/read with BYPASS=1: write_enable=1, write_reg=5, write_d=500, read_reg0=5 in the same cycle -> read_d0=500 before the edge and after. With BYPASS=0 -> old value 0 before the edge, 500 after.
- Zero register: write reg0=0xDEADBEEF -> reads of reg0 on all ports return 0, including the bypass cycle. pend_set on reg0 -> any_pending stays 0.
- Scoreboard:
  - pend_set reg7 at cycle 1 -> read_busy=1 for a port reading 7 from cycle 2;
  - write reg7=0x1234 at cycle 4 -> busy masked in cycle 4, 0 afterwards, read_d=0x1234.
- Simultaneous set and clear on reg9 in one cycle -> pending[9] stays 1. Set reg3 plus write reg4 -> pending[3]=1, pending[4]=0.
- Parametrisation: NUM_REGS=24, NUM_RD=3 -> write to index 30 dropped and read of 30 returns 0. Three ports reading 1, 1, 23 return the correct distinct data.
